// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and variable-latency instruction fetch FSM
//
// Holds the program counter and fetches the instruction at pc from an
// instruction memory over a req/ack handshake, presenting a held instruction
// to a multicycle CPU.
//
// Ports:
//   clk_in      clock, rising edge
//   reset       synchronous, active-high
//   fetch_go    CPU accepts inst, loads pc_next (VALID only)
//   pc_next     next PC from CPU
//   trap_req    redirect to TRAP_VECTOR (VALID and FAULT only)
//   imem_req    fetch request, high throughout REQ
//   imem_addr   imem word index derived from pc
//   imem_ack    imem_rdata valid this cycle
//   imem_rdata  instruction word from imem
//   pc          current PC
//   inst        latched instruction
//   inst_valid  inst holds the word fetched from pc
//   fetch_fault sticky fault: bad pc or ack timeout

module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
    parameter logic [31:0] IMEM_BASE    = 32'h0040_0000,
    parameter int          IMEM_AW      = 11,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0040_0004,
    parameter int          ACK_TIMEOUT  = 15
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               fetch_go,
    input  logic [31:0]        pc_next,
    input  logic               trap_req,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        inst,
    output logic               inst_valid,
    output logic               fetch_fault
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_CHECK = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [31:0]   pc_q, pc_nx;
    logic [31:0]   inst_q, inst_nx;
    logic [CW-1:0] count, count_nx;

    logic [31:0]   offset;
    logic          bad_pc;

    // Offset into the imem window; wraps for pc below the base, which the
    // explicit pc < IMEM_BASE term catches.
    assign offset = pc_q - IMEM_BASE;

    // Window size compared at 64 bits so large IMEM_AW cannot overflow.
    assign bad_pc = (pc_q[1:0] != 2'b00) ||
                    (pc_q < IMEM_BASE) ||
                    ({32'd0, offset} >= (64'd4 << IMEM_AW));

    assign imem_addr   = offset[IMEM_AW+1:2];
    assign imem_req    = (state == S_REQ);
    assign inst_valid  = (state == S_VALID);
    assign fetch_fault = (state == S_FAULT);
    assign pc          = pc_q;
    assign inst        = inst_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state  <= S_CHECK;
            pc_q   <= RESET_VECTOR;
            inst_q <= 32'd0;
            count  <= '0;
        end else begin
            state  <= state_nx;
            pc_q   <= pc_nx;
            inst_q <= inst_nx;
            count  <= count_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        inst_nx  = inst_q;
        count_nx = count;
        case (state)
            S_CHECK: begin
                count_nx = '0;
                state_nx = bad_pc ? S_FAULT : S_REQ;
            end
            S_REQ: begin
                // Ack is checked first so an ack on the last allowed cycle
                // still completes the fetch.
                if (imem_ack) begin
                    inst_nx  = imem_rdata;
                    state_nx = S_VALID;
                end else if (count == CW'(ACK_TIMEOUT - 1)) begin
                    state_nx = S_FAULT;
                end else begin
                    count_nx = count + 1'b1;
                end
            end
            S_VALID: begin
                if (trap_req) begin
                    pc_nx    = TRAP_VECTOR;
                    state_nx = S_CHECK;
                end else if (fetch_go) begin
                    pc_nx    = pc_next;
                    state_nx = S_CHECK;
                end
            end
            S_FAULT: begin
                if (trap_req) begin
                    pc_nx    = TRAP_VECTOR;
                    state_nx = S_CHECK;
                end
            end
            default: state_nx = S_CHECK;
        endcase
    end

endmodule
